// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register for RV32I: handshake capture, ALU op decode, operand select.
// Optional MEM/WB operand forwarding is enabled with `define ID_EX_FORWARD_EN.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_opcode,
  output logic            ex_illegal,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_in_a,
  output logic [XLEN-1:0] alu_in_b,
  output logic [XLEN-1:0] ex_rs2_fwd,
  input  logic            fwd_mem_valid,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data
);
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010,
                         ALU_SLT = 4'b0011, ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101,
                         ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_OR = 4'b1000,
                         ALU_AND = 4'b1001;
  localparam logic [1:0] ASEL_RS1 = 2'd0, ASEL_PC = 2'd1, ASEL_ZERO = 2'd2;
  localparam logic [1:0] BSEL_RS2 = 2'd0, BSEL_IMM = 2'd1, BSEL_FOUR = 2'd2;

  logic            valid_q, valid_d, illegal_q, illegal_d;
  logic [3:0]      aluc_q, aluc_d;
  logic [1:0]      asel_q, asel_d, bsel_q, bsel_d;
  logic [XLEN-1:0] pc_q, rs1_val_q, rs2_val_q, imm_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      funct3_q;
  logic [6:0]      opcode_q;
  logic            capture;
  logic [XLEN-1:0] rs1_op, rs2_op;

  assign id_ready = !valid_q || ex_ready;
  assign capture  = id_valid && id_ready;

  // Decode of the incoming instruction; result is registered on capture.
  always_comb begin
    aluc_d    = ALU_ADD;
    asel_d    = ASEL_RS1;
    bsel_d    = BSEL_IMM;
    illegal_d = 1'b0;
    unique case (id_opcode)
      7'b0110011, 7'b0010011: begin
        bsel_d = (id_opcode == 7'b0110011) ? BSEL_RS2 : BSEL_IMM;
        unique case (id_funct3)
          3'b000: aluc_d = (id_funct7b5 && id_opcode == 7'b0110011) ? ALU_SUB : ALU_ADD;
          3'b001: aluc_d = ALU_SLL;
          3'b010: aluc_d = ALU_SLT;
          3'b011: aluc_d = ALU_SLTU;
          3'b100: aluc_d = ALU_XOR;
          3'b101: aluc_d = id_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: aluc_d = ALU_OR;
          default: aluc_d = ALU_AND;
        endcase
      end
      7'b0000011, 7'b0100011: ;
      7'b0110111: asel_d = ASEL_ZERO;
      7'b0010111: asel_d = ASEL_PC;
      7'b1101111, 7'b1100111: begin
        asel_d = ASEL_PC;
        bsel_d = BSEL_FOUR;
      end
      7'b1100011: begin
        bsel_d = BSEL_RS2;
        unique case (id_funct3[2:1])
          2'b00:   aluc_d = ALU_SUB;
          2'b10:   aluc_d = ALU_SLT;
          2'b11:   aluc_d = ALU_SLTU;
          default: aluc_d = ALU_ADD;
        endcase
      end
      default: begin
        illegal_d = 1'b1;
        asel_d    = ASEL_ZERO;
        bsel_d    = BSEL_FOUR;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (flush)         valid_d = 1'b0;
    else if (capture)  valid_d = 1'b1;
    else if (ex_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      aluc_q    <= '0;
      asel_q    <= '0;
      bsel_q    <= '0;
      pc_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      opcode_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        illegal_q <= illegal_d;
        aluc_q    <= aluc_d;
        asel_q    <= asel_d;
        // Illegal ops force b to zero via an all-zero immediate path below.
        bsel_q    <= illegal_d ? BSEL_IMM : bsel_d;
        imm_q     <= illegal_d ? '0 : id_imm;
        pc_q      <= id_pc;
        rs1_val_q <= id_rs1_val;
        rs2_val_q <= id_rs2_val;
        rd_q      <= id_rd;
        rs1_q     <= id_rs1;
        rs2_q     <= id_rs2;
        funct3_q  <= id_funct3;
        opcode_q  <= id_opcode;
      end
    end
  end

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    rs1_op = rs1_val_q;
    if (fwd_mem_valid && fwd_mem_rd == rs1_q && rs1_q != 5'd0)     rs1_op = fwd_mem_data;
    else if (fwd_wb_valid && fwd_wb_rd == rs1_q && rs1_q != 5'd0)  rs1_op = fwd_wb_data;
    rs2_op = rs2_val_q;
    if (fwd_mem_valid && fwd_mem_rd == rs2_q && rs2_q != 5'd0)     rs2_op = fwd_mem_data;
    else if (fwd_wb_valid && fwd_wb_rd == rs2_q && rs2_q != 5'd0)  rs2_op = fwd_wb_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_valid, fwd_wb_rd, fwd_wb_data, rs1_q, rs2_q};
  assign rs1_op = rs1_val_q;
  assign rs2_op = rs2_val_q;
`endif

  always_comb begin
    unique case (asel_q)
      ASEL_RS1: alu_in_a = rs1_op;
      ASEL_PC:  alu_in_a = pc_q;
      default:  alu_in_a = '0;
    endcase
    unique case (bsel_q)
      BSEL_RS2: alu_in_b = rs2_op;
      BSEL_IMM: alu_in_b = imm_q;
      default:  alu_in_b = XLEN'(4);
    endcase
  end

  assign ex_valid    = valid_q;
  assign ex_illegal  = illegal_q;
  assign alu_control = aluc_q;
  assign ex_pc       = pc_q;
  assign ex_rd       = rd_q;
  assign ex_funct3   = funct3_q;
  assign ex_opcode   = opcode_q;
  assign ex_rs2_fwd  = rs2_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        id_valid = 1'b0, id_ready, id_funct7b5 = 1'b0;
  logic [31:0] id_pc = '0, id_rs1_val = '0, id_rs2_val = '0, id_imm = '0;
  logic [6:0]  id_opcode = '0, ex_opcode;
  logic [2:0]  id_funct3 = '0, ex_funct3;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, ex_rd;
  logic        ex_ready = 1'b1, ex_valid, ex_illegal;
  logic [31:0] ex_pc, alu_in_a, alu_in_b, ex_rs2_fwd;
  logic [3:0]  alu_control;
  logic        fwd_mem_valid = 1'b0, fwd_wb_valid = 1'b0;
  logic [4:0]  fwd_mem_rd = '0, fwd_wb_rd = '0;
  logic [31:0] fwd_mem_data = '0, fwd_wb_data = '0;
  int errors = 0, checks = 0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_imm(id_imm), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_opcode(ex_opcode),
    .ex_illegal(ex_illegal), .alu_control(alu_control), .alu_in_a(alu_in_a),
    .alu_in_b(alu_in_b), .ex_rs2_fwd(ex_rs2_fwd), .fwd_mem_valid(fwd_mem_valid),
    .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data), .fwd_wb_valid(fwd_wb_valid),
    .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    id_valid = 1'b1; id_opcode = op; id_funct3 = f3; id_funct7b5 = f7;
    id_rs1_val = a; id_rs2_val = b; id_imm = imm;
  endtask

  initial begin
    #3;
    chk("rst_valid", ex_valid, 0);
    chk("rst_aluc", alu_control, 0);
    chk("rst_illegal", ex_illegal, 0);
    chk("rst_a", alu_in_a, 0);
    chk("rst_ready", id_ready, 1);
    id_rd = 5'd7;
    drive(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'h0);
    #9 rst_n = 1'b1;
    step();
    chk("add_valid", ex_valid, 1);
    chk("add_aluc", alu_control, 4'b0000);
    chk("add_a", alu_in_a, 5);
    chk("add_b", alu_in_b, 7);
    chk("add_rd", ex_rd, 7);
    drive(7'b0110011, 3'b000, 1'b1, 32'd9, 32'd2, 32'h0);
    step();
    chk("sub_aluc", alu_control, 4'b0001);
    drive(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4);
    step();
    chk("srai_aluc", alu_control, 4'b0111);
    chk("srai_a", alu_in_a, 32'h8000_0000);
    chk("srai_b", alu_in_b, 4);
    drive(7'b0010011, 3'b000, 1'b1, 32'd1, 32'd2, 32'd3);
    step();
    chk("addi_f7_aluc", alu_control, 4'b0000);
    drive(7'b0110111, 3'b000, 1'b0, 32'h55, 32'h66, 32'h1234_5000);
    step();
    chk("lui_a", alu_in_a, 0);
    chk("lui_b", alu_in_b, 32'h1234_5000);
    id_pc = 32'h1000;
    drive(7'b0010111, 3'b000, 1'b0, 32'h55, 32'h66, 32'h2000);
    step();
    chk("auipc_a", alu_in_a, 32'h1000);
    chk("auipc_b", alu_in_b, 32'h2000);
    id_pc = 32'h40;
    drive(7'b1101111, 3'b000, 1'b0, 32'h55, 32'h66, 32'h800);
    step();
    chk("jal_a", alu_in_a, 32'h40);
    chk("jal_b", alu_in_b, 4);
    chk("jal_pc", ex_pc, 32'h40);
    drive(7'b1100011, 3'b101, 1'b0, 32'h11, 32'h22, 32'h10);
    step();
    chk("bge_aluc", alu_control, 4'b0011);
    chk("bge_b", alu_in_b, 32'h22);
    drive(7'b1100011, 3'b110, 1'b0, 32'h11, 32'h22, 32'h10);
    step();
    chk("bltu_aluc", alu_control, 4'b0100);
    chk("bltu_f3", ex_funct3, 3'b110);
    drive(7'b1111111, 3'b111, 1'b1, 32'h11, 32'h22, 32'h10);
    step();
    chk("ill_flag", ex_illegal, 1);
    chk("ill_valid", ex_valid, 1);
    chk("ill_aluc", alu_control, 0);
    chk("ill_a", alu_in_a, 0);
    chk("ill_b", alu_in_b, 0);
    // Backpressure: OR held while AND waits.
    drive(7'b0110011, 3'b110, 1'b0, 32'd1, 32'd2, 32'h0);
    step();
    chk("or_illegal_clr", ex_illegal, 0);
    ex_ready = 1'b0;
    drive(7'b0110011, 3'b111, 1'b0, 32'd9, 32'd3, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", id_ready, 0);
      chk("bp_aluc", alu_control, 4'b1000);
      chk("bp_a", alu_in_a, 1);
      chk("bp_valid", ex_valid, 1);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", id_ready, 1);
    step();
    chk("bp_and_aluc", alu_control, 4'b1001);
    chk("bp_and_a", alu_in_a, 9);
    id_valid = 1'b0;
    step();
    chk("drain_valid", ex_valid, 0);
    // Flush on a capture cycle, then recovery.
    flush = 1'b1;
    drive(7'b0110011, 3'b100, 1'b0, 32'd4, 32'd5, 32'h0);
    step();
    chk("flush_valid", ex_valid, 0);
    flush = 1'b0;
    step();
    chk("post_flush_valid", ex_valid, 1);
    chk("post_flush_aluc", alu_control, 4'b0101);
    ex_ready = 1'b0; id_valid = 1'b0; flush = 1'b1;
    step();
    chk("flush_hold_valid", ex_valid, 0);
    flush = 1'b0; ex_ready = 1'b1;
    // Forwarding priority.
    id_rs1 = 5'd3; id_rs2 = 5'd4;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'h100;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'h200;
    drive(7'b0110011, 3'b000, 1'b0, 32'h55, 32'h77, 32'h0);
    step();
    id_valid = 1'b0;
`ifdef ID_EX_FORWARD_EN
    chk("fwd_mem_a", alu_in_a, 32'h100);
`else
    chk("fwd_mem_a", alu_in_a, 32'h55);
`endif
    fwd_mem_valid = 1'b0;
    #1;
`ifdef ID_EX_FORWARD_EN
    chk("fwd_wb_a", alu_in_a, 32'h200);
`else
    chk("fwd_wb_a", alu_in_a, 32'h55);
`endif
    chk("fwd_rs2_nomatch", ex_rs2_fwd, 32'h77);
    step();
    id_rs1 = 5'd0; fwd_wb_rd = 5'd0; fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd0;
    drive(7'b0110011, 3'b000, 1'b0, 32'h66, 32'h77, 32'h0);
    step();
    chk("fwd_x0_a", alu_in_a, 32'h66);
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
    // Asynchronous reset while an instruction is held.
    drive(7'b0110011, 3'b000, 1'b1, 32'd8, 32'd1, 32'h0);
    step();
    chk("pre_rst_aluc", alu_control, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_aluc", alu_control, 0);
    chk("mid_rst_a", alu_in_a, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
